// File: rtl/seq_pkg.sv
// Shared definitions for the CPU sequencer: FSM state encoding, opcode
// classes and the default memory wait limit.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_JUMP   = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_IALU  = 3'b001;
   localparam logic [2:0] OP_LW    = 3'b010;
   localparam logic [2:0] OP_SW    = 3'b011;
   localparam logic [2:0] OP_BEQ   = 3'b100;
   localparam logic [2:0] OP_JR    = 3'b101;
   localparam logic [2:0] OP_J     = 3'b110;
   localparam logic [2:0] OP_JAL   = 3'b111;

   localparam int MEM_WAIT_MAX_DEF = 15;

   // Jump-class instructions skip EXEC and go straight to the JUMP state.
   function automatic logic isJumpOp(input logic [2:0] op);
      return (op == OP_JR) || (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive memory request cycles without mem_ready and flags a
// timeout in the cycle the count would exceed MEM_WAIT_MAX.
module seq_wait_timer
   import seq_pkg::*;
#(
   parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_req,
   input  logic i_ready,
   output logic o_timeout
);

   localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX);

   logic [CW-1:0] r_count;
   logic          w_waiting;

   assign w_waiting = i_req & ~i_ready;

   // Any cycle that is not an unanswered request restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (!w_waiting) begin
         r_count <= '0;
      end else if (r_count != LIMIT) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_timeout = w_waiting & (r_count == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer (fetch/decode/execute/memory/writeback).
// Define SEQ_RETIRE_CNT_EN to add the saturating retired-instruction counter.
module cpu_sequencer
   import seq_pkg::*;
#(
   parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        step_mode,
   input  logic        halt_req,
   input  logic [2:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_load,
   output logic        pc_inc,
   output logic        pc_branch,
   output logic        pc_jump,
   output logic        alu_en,
   output logic        reg_write,
   output logic        ra_sel,
   output logic        busy,
   output logic        fault,
   output logic [2:0]  state
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [15:0] retired
`endif
);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_opcode;
   logic       r_halt;
   logic       w_retire;
   logic       w_stop;
   logic       w_memReq;
   logic       w_timeout;

   assign w_memReq = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_stop   = step_mode | r_halt | halt_req;

   seq_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_waitTimer (
      .clk       (clk),
      .reset     (reset),
      .i_req     (w_memReq),
      .i_ready   (mem_ready),
      .o_timeout (w_timeout)
   );

   // The opcode is captured in DECODE so later strobes depend only on registered state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_halt   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opcode <= opcode;
         end
         if (w_next == S_IDLE) begin
            r_halt <= 1'b0;
         end else if (busy && halt_req) begin
            r_halt <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      mem_we    = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_branch = 1'b0;
      pc_jump   = 1'b0;
      alu_en    = 1'b0;
      reg_write = 1'b0;
      ra_sel    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               w_next  = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end
         end
         S_DECODE: begin
            w_next = isJumpOp(opcode) ? S_JUMP : S_EXEC;
         end
         S_EXEC: begin
            alu_en = 1'b1;
            case (r_opcode)
               OP_RTYPE, OP_IALU: w_next = S_WB;
               OP_LW, OP_SW:      w_next = S_MEM;
               default: begin
                  pc_branch = (r_opcode == OP_BEQ) & alu_zero;
                  w_retire  = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            mem_we = (r_opcode == OP_SW);
            if (mem_ready) begin
               if (r_opcode == OP_SW) w_retire = 1'b1;
               else                   w_next   = S_WB;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            w_retire  = 1'b1;
         end
         S_JUMP: begin
            pc_jump = 1'b1;
            if (r_opcode == OP_JAL) begin
               reg_write = 1'b1;
               ra_sel    = 1'b1;
            end
            w_retire = 1'b1;
         end
         S_FAULT: begin
            w_next = S_FAULT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      if (w_retire) begin
         w_next = w_stop ? S_IDLE : S_FETCH;
      end
   end

   assign mem_req = w_memReq;
   assign busy    = (r_state != S_IDLE) && (r_state != S_FAULT);
   assign fault   = (r_state == S_FAULT);
   assign state   = r_state;

`ifdef SEQ_RETIRE_CNT_EN
   logic [15:0] r_retired;

   // Saturates so long runs never wrap back to a misleading small count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= '0;
      end else if (w_retire && (r_retired != 16'hFFFF)) begin
         r_retired <= r_retired + 16'd1;
      end
   end

   assign retired = r_retired;
`endif

endmodule
